// File: rtl/ads111x_i2c_target.sv
// ADS111x-compatible I2C target: conditions SCL/SDA, decodes the bus and
// serves the pointer, conversion, config, Lo_thresh and Hi_thresh registers.
`timescale 1ns/1ps

module ads111x_i2c_target #(
    parameter logic [1:0] ADDR_PIN = 2'b00,
    parameter int         FILT_LEN = 3,
    parameter int         HOLD_CYC = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        conv_start,
    input  logic        conv_done,
    input  logic [15:0] conv_data,
    output logic [15:0] cfg_o,
    output logic [15:0] lo_thresh_o,
    output logic [15:0] hi_thresh_o
);

    localparam logic [6:0]        DEV_ADDR  = {5'b10010, ADDR_PIN};
    localparam int                CNT_W     = $clog2(FILT_LEN) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(FILT_LEN - 1);
    localparam int                HOLD_W    = $clog2(HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK, ST_WR_MSB, ST_WR_MSB_ACK,
        ST_WR_LSB, ST_WR_LSB_ACK, ST_RD_BYTE, ST_RD_ACK, ST_IGNORE
    } state_t;

    // Input conditioning state
    logic             scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
    logic             sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
    logic             scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic             scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [CNT_W-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

    // Protocol and register state
    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [7:0]        msb_q, msb_d;
    logic [6:0]        tx_q, tx_d;
    logic [7:0]        lsb_q, lsb_d;
    logic              rd_lsb_q, rd_lsb_d;
    logic              rd_mode_q, rd_mode_d;
    logic              sda_oe_q, sda_oe_d;
    logic              pend_oe_q, pend_oe_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [14:0]       cfg_q, cfg_d;
    logic [15:0]       lo_q, lo_d, hi_q, hi_d, conv_q, conv_d;
    logic              busy_q, busy_d;
    logic              conv_start_q, conv_start_d;
    logic [15:0]       rd_word;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;
    logic [15:0] wr_word;

    assign scl_rise  = scl_f_q & ~scl_prev_q;
    assign scl_fall  = ~scl_f_q & scl_prev_q;
    assign start_det = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
    assign stop_det  = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;
    assign rx_byte   = {shift_q, sda_f_q};
    assign wr_word   = {msb_q, rx_byte};

    // Config OS bit reads as "not busy"; the stored OS is implicitly 1
    assign sda_oe      = sda_oe_q;
    assign conv_start  = conv_start_q;
    assign cfg_o       = {~busy_q, cfg_q};
    assign lo_thresh_o = lo_q;
    assign hi_thresh_o = hi_q;

    // Synchronizer, glitch filter and previous-level registers; idle bus is high
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
        end else begin
            scl_s1_q   <= scl_s1_d;
            scl_s2_q   <= scl_s2_d;
            sda_s1_q   <= sda_s1_d;
            sda_s2_q   <= sda_s2_d;
            scl_f_q    <= scl_f_d;
            sda_f_q    <= sda_f_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            scl_cnt_q  <= scl_cnt_d;
            sda_cnt_q  <= sda_cnt_d;
        end
    end

    // A filtered level flips only after FILT_LEN consecutive differing samples
    always_comb begin
        scl_s1_d   = scl_i;
        scl_s2_d   = scl_s1_q;
        sda_s1_d   = sda_i;
        sda_s2_d   = sda_s1_q;
        scl_f_d    = scl_f_q;
        sda_f_d    = sda_f_q;
        scl_cnt_d  = '0;
        sda_cnt_d  = '0;
        scl_prev_d = scl_f_q;
        sda_prev_d = sda_f_q;
        if (scl_s2_q != scl_f_q) begin
            if (scl_cnt_q == CNT_MAX) scl_f_d = scl_s2_q;
            else                      scl_cnt_d = scl_cnt_q + CNT_W'(1);
        end
        if (sda_s2_q != sda_f_q) begin
            if (sda_cnt_q == CNT_MAX) sda_f_d = sda_s2_q;
            else                      sda_cnt_d = sda_cnt_q + CNT_W'(1);
        end
    end

    // Protocol state, register file and SDA driver registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            ptr_q        <= '0;
            msb_q        <= '0;
            tx_q         <= '0;
            lsb_q        <= '0;
            rd_lsb_q     <= 1'b0;
            rd_mode_q    <= 1'b0;
            sda_oe_q     <= 1'b0;
            pend_oe_q    <= 1'b0;
            hold_q       <= '0;
            cfg_q        <= 15'h0583;
            lo_q         <= 16'h8000;
            hi_q         <= 16'h7FFF;
            conv_q       <= 16'h0000;
            busy_q       <= 1'b0;
            conv_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ptr_q        <= ptr_d;
            msb_q        <= msb_d;
            tx_q         <= tx_d;
            lsb_q        <= lsb_d;
            rd_lsb_q     <= rd_lsb_d;
            rd_mode_q    <= rd_mode_d;
            sda_oe_q     <= sda_oe_d;
            pend_oe_q    <= pend_oe_d;
            hold_q       <= hold_d;
            cfg_q        <= cfg_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            conv_q       <= conv_d;
            busy_q       <= busy_d;
            conv_start_q <= conv_start_d;
        end
    end

    // Next-state logic: byte shifting, ACK/data scheduling, register writes and conversion handshake
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ptr_d        = ptr_q;
        msb_d        = msb_q;
        tx_d         = tx_q;
        lsb_d        = lsb_q;
        rd_lsb_d     = rd_lsb_q;
        rd_mode_d    = rd_mode_q;
        sda_oe_d     = sda_oe_q;
        pend_oe_d    = pend_oe_q;
        hold_d       = hold_q;
        cfg_d        = cfg_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        conv_d       = conv_q;
        busy_d       = busy_q;
        conv_start_d = 1'b0;

        case (ptr_q)
            2'd0:    rd_word = conv_q;
            2'd1:    rd_word = {~busy_q, cfg_q};
            2'd2:    rd_word = lo_q;
            default: rd_word = hi_q;
        endcase

        if (conv_done) begin
            conv_d = conv_data;
            busy_d = 1'b0;
        end

        if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
            if (hold_q == HOLD_W'(1)) sda_oe_d = pend_oe_q;
        end

        if (start_det || stop_det) begin
            state_d   = start_det ? ST_ADDR : ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            hold_d    = '0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WR_MSB, ST_WR_LSB: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            case (state_q)
                                ST_ADDR: begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        rd_mode_d = rx_byte[0];
                                        state_d   = ST_ADDR_ACK;
                                    end else begin
                                        state_d = ST_IGNORE;
                                    end
                                end
                                ST_PTR: begin
                                    ptr_d   = rx_byte[1:0];
                                    state_d = ST_PTR_ACK;
                                end
                                ST_WR_MSB: begin
                                    msb_d   = rx_byte;
                                    state_d = ST_WR_MSB_ACK;
                                end
                                default: begin
                                    case (ptr_q)
                                        2'd1: begin
                                            cfg_d = wr_word[14:0];
                                            if (wr_word[15] && !busy_d) begin
                                                conv_start_d = 1'b1;
                                                busy_d       = 1'b1;
                                            end
                                        end
                                        2'd2:    lo_d = wr_word;
                                        2'd3:    hi_d = wr_word;
                                        default: ;
                                    endcase
                                    state_d = ST_WR_LSB_ACK;
                                end
                            endcase
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WR_MSB_ACK, ST_WR_LSB_ACK: begin
                    if (scl_rise) bit_cnt_d = 4'd9;
                    if (scl_fall && bit_cnt_q == 4'd8) begin
                        hold_d    = HOLD_LOAD;
                        pend_oe_d = 1'b1;
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        bit_cnt_d = '0;
                        hold_d    = HOLD_LOAD;
                        pend_oe_d = 1'b0;
                        case (state_q)
                            ST_ADDR_ACK: begin
                                if (rd_mode_q) begin
                                    tx_d      = rd_word[14:8];
                                    lsb_d     = rd_word[7:0];
                                    pend_oe_d = ~rd_word[15];
                                    rd_lsb_d  = 1'b1;
                                    state_d   = ST_RD_BYTE;
                                end else begin
                                    state_d = ST_PTR;
                                end
                            end
                            ST_WR_MSB_ACK: state_d = ST_WR_LSB;
                            default:       state_d = ST_WR_MSB;
                        endcase
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
                    if (scl_fall && bit_cnt_q == 4'd8) begin
                        hold_d    = HOLD_LOAD;
                        pend_oe_d = 1'b0;
                        state_d   = ST_RD_ACK;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        hold_d    = HOLD_LOAD;
                        pend_oe_d = ~tx_q[6];
                        tx_d      = {tx_q[5:0], 1'b0};
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_d = 4'd9;
                        if (sda_f_q) state_d = ST_IGNORE;
                    end
                    if (scl_fall && bit_cnt_q == 4'd9) begin
                        bit_cnt_d = '0;
                        hold_d    = HOLD_LOAD;
                        state_d   = ST_RD_BYTE;
                        if (rd_lsb_q) begin
                            tx_d      = lsb_q[6:0];
                            pend_oe_d = ~lsb_q[7];
                            rd_lsb_d  = 1'b0;
                        end else begin
                            tx_d      = rd_word[14:8];
                            lsb_d     = rd_word[7:0];
                            pend_oe_d = ~rd_word[15];
                            rd_lsb_d  = 1'b1;
                        end
                    end
                end
                ST_IDLE, ST_IGNORE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ads111x_i2c_target.sv
// Directed bench for ads111x_i2c_target: a bit-banged I2C master drives the
// bus and each scenario task checks ACKs, read bytes and register outputs.
`timescale 1ns/1ps

module tb_ads111x_i2c_target;

    localparam int Q = 15;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        scl_m, sda_m;
    logic        sda_line;
    logic        sda_oe, conv_start, conv_done;
    logic [15:0] conv_data, cfg_o, lo_thresh_o, hi_thresh_o;
    int          errors, checks, start_cnt, oe_cnt;
    logic        mon_en;

    assign sda_line = sda_m & ~sda_oe;

    ads111x_i2c_target dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .scl_i       (scl_m),
        .sda_i       (sda_line),
        .sda_oe      (sda_oe),
        .conv_start  (conv_start),
        .conv_done   (conv_done),
        .conv_data   (conv_data),
        .cfg_o       (cfg_o),
        .lo_thresh_o (lo_thresh_o),
        .hi_thresh_o (hi_thresh_o)
    );

    always #5 sys_clk = ~sys_clk;

    // Count conv_start pulses and any SDA drive inside a monitored window
    always @(posedge sys_clk) begin
        if (conv_start) start_cnt++;
        if (mon_en && sda_oe) oe_cnt++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitq();
        repeat (Q) @(posedge sys_clk);
        #1;
    endtask

    task automatic i2c_start();
        if (scl_m == 1'b0) begin
            waitq(); sda_m = 1'b1;
            waitq(); scl_m = 1'b1;
            waitq();
        end
        sda_m = 1'b0;
        waitq(); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        waitq(); sda_m = 1'b0;
        waitq(); scl_m = 1'b1;
        waitq(); sda_m = 1'b1;
        waitq();
    endtask

    // One SCL period; optional one-cycle SDA low glitch in the middle of the high phase
    task automatic bit_xfer(input logic b, input logic glitch, output logic s);
        waitq(); sda_m = b;
        waitq(); scl_m = 1'b1;
        if (glitch) begin
            repeat (Q / 2) @(posedge sys_clk);
            #1 sda_m = 1'b0;
            @(posedge sys_clk);
            #1 sda_m = 1'b1;
            repeat (Q - Q / 2 - 1) @(posedge sys_clk);
            #1;
        end else begin
            waitq();
        end
        s = sda_line;
        waitq(); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic [7:0] gmask, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], gmask[i], s);
        bit_xfer(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic ack_out, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 1'b0, s);
            b[i] = s;
        end
        bit_xfer(~ack_out, 1'b0, s);
    endtask

    task automatic pulse_done(input logic [15:0] d);
        @(posedge sys_clk); #1;
        conv_data = d; conv_done = 1'b1;
        @(posedge sys_clk); #1;
        conv_done = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        conv_done = 1'b0; conv_data = 16'h0000; mon_en = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL rst_sda_oe got=%b exp=0", sda_oe); end
        checks++; if (conv_start !== 1'b0) begin errors++; $display("[TB] FAIL rst_conv_start got=%b exp=0", conv_start); end
        checks++; if (cfg_o !== 16'h8583) begin errors++; $display("[TB] FAIL rst_cfg got=%h exp=8583", cfg_o); end
        checks++; if (lo_thresh_o !== 16'h8000) begin errors++; $display("[TB] FAIL rst_lo got=%h exp=8000", lo_thresh_o); end
        checks++; if (hi_thresh_o !== 16'h7FFF) begin errors++; $display("[TB] FAIL rst_hi got=%h exp=7fff", hi_thresh_o); end
        sys_rst = 1'b0;
        repeat (20) @(posedge sys_clk);
        #1;
    endtask

    task automatic test_read_ptr0();
        logic ack; logic [7:0] b0, b1;
        i2c_start();
        write_byte(8'h91, 8'h00, ack);
        read_byte(1'b1, b0);
        read_byte(1'b0, b1);
        i2c_stop();
        repeat (10) @(posedge sys_clk);
        #1;
        checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL rd0_addr_ack got=%b exp=1", ack); end
        checks++; if (b0 !== 8'h00) begin errors++; $display("[TB] FAIL rd0_msb got=%h exp=00", b0); end
        checks++; if (b1 !== 8'h00) begin errors++; $display("[TB] FAIL rd0_lsb got=%h exp=00", b1); end
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL rd0_stop_release got=%b exp=0", sda_oe); end
    endtask

    task automatic test_cfg_write();
        logic [3:0] acks; logic ack; logic [7:0] b0, b1; int s0;
        s0 = start_cnt;
        i2c_start();
        write_byte(8'h90, 8'h00, acks[3]);
        write_byte(8'h01, 8'h00, acks[2]);
        write_byte(8'hC4, 8'h00, acks[1]);
        write_byte(8'hE3, 8'h00, acks[0]);
        i2c_stop();
        checks++; if (acks !== 4'hF) begin errors++; $display("[TB] FAIL cfg_wr_acks got=%b exp=1111", acks); end
        checks++; if (cfg_o !== 16'h44E3) begin errors++; $display("[TB] FAIL cfg_wr_value got=%h exp=44e3", cfg_o); end
        checks++; if (start_cnt - s0 !== 1) begin errors++; $display("[TB] FAIL cfg_conv_start_pulses got=%0d exp=1", start_cnt - s0); end
        i2c_start();
        write_byte(8'h91, 8'h00, ack);
        read_byte(1'b1, b0);
        read_byte(1'b0, b1);
        i2c_stop();
        checks++; if ({ack, b0, b1} !== {1'b1, 16'h44E3}) begin errors++; $display("[TB] FAIL cfg_rd_busy got=%b/%h%h exp=1/44e3", ack, b0, b1); end
        pulse_done(16'h1234);
        i2c_start();
        write_byte(8'h91, 8'h00, ack);
        read_byte(1'b1, b0);
        read_byte(1'b0, b1);
        i2c_stop();
        checks++; if ({ack, b0, b1} !== {1'b1, 16'hC4E3}) begin errors++; $display("[TB] FAIL cfg_rd_done got=%b/%h%h exp=1/c4e3", ack, b0, b1); end
    endtask

    task automatic test_conv_read();
        logic [2:0] acks; logic [7:0] b0, b1, b2, b3;
        i2c_start();
        write_byte(8'h90, 8'h00, acks[2]);
        write_byte(8'h00, 8'h00, acks[1]);
        i2c_start();
        write_byte(8'h91, 8'h00, acks[0]);
        read_byte(1'b1, b0);
        read_byte(1'b1, b1);
        read_byte(1'b1, b2);
        read_byte(1'b0, b3);
        i2c_stop();
        checks++; if (acks !== 3'b111) begin errors++; $display("[TB] FAIL conv_acks got=%b exp=111", acks); end
        checks++; if ({b0, b1, b2, b3} !== 32'h12341234) begin errors++; $display("[TB] FAIL conv_rd4 got=%h%h%h%h exp=12341234", b0, b1, b2, b3); end
    endtask

    task automatic test_mid_read_done();
        logic ack; logic [7:0] b0, b1, b2;
        i2c_start();
        write_byte(8'h91, 8'h00, ack);
        read_byte(1'b1, b0);
        pulse_done(16'h5678);
        read_byte(1'b1, b1);
        read_byte(1'b0, b2);
        i2c_stop();
        checks++; if ({b0, b1} !== 16'h1234) begin errors++; $display("[TB] FAIL mid_done_snapshot got=%h%h exp=1234", b0, b1); end
        checks++; if (b2 !== 8'h56) begin errors++; $display("[TB] FAIL mid_done_next_msb got=%h exp=56", b2); end
    endtask

    task automatic test_addr_mismatch();
        logic ack; int c0;
        c0 = oe_cnt;
        mon_en = 1'b1;
        i2c_start();
        write_byte(8'h92, 8'h00, ack);
        mon_en = 1'b0;
        checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL mismatch_ack got=%b exp=0", ack); end
        checks++; if (oe_cnt - c0 !== 0) begin errors++; $display("[TB] FAIL mismatch_sda_oe cycles=%0d exp=0", oe_cnt - c0); end
        i2c_start();
        write_byte(8'h90, 8'h00, ack);
        i2c_stop();
        checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL mismatch_then_match_ack got=%b exp=1", ack); end
    endtask

    task automatic test_partial_write();
        logic [3:0] acks; logic ack; logic [7:0] b0, b1;
        i2c_start();
        write_byte(8'h90, 8'h00, acks[3]);
        write_byte(8'h02, 8'h00, acks[2]);
        write_byte(8'hAB, 8'h00, acks[1]);
        i2c_stop();
        checks++; if (acks[3:1] !== 3'b111) begin errors++; $display("[TB] FAIL partial_acks got=%b exp=111", acks[3:1]); end
        checks++; if (lo_thresh_o !== 16'h8000) begin errors++; $display("[TB] FAIL partial_lo got=%h exp=8000", lo_thresh_o); end
        i2c_start();
        write_byte(8'h91, 8'h00, ack);
        read_byte(1'b1, b0);
        read_byte(1'b0, b1);
        i2c_stop();
        checks++; if ({b0, b1} !== 16'h8000) begin errors++; $display("[TB] FAIL partial_ptr2_read got=%h%h exp=8000", b0, b1); end
        i2c_start();
        write_byte(8'h90, 8'h00, acks[3]);
        write_byte(8'h03, 8'h00, acks[2]);
        write_byte(8'h12, 8'h00, acks[1]);
        write_byte(8'h34, 8'h00, acks[0]);
        i2c_stop();
        checks++; if (hi_thresh_o !== 16'h1234) begin errors++; $display("[TB] FAIL hi_write got=%h exp=1234", hi_thresh_o); end
    endtask

    task automatic test_glitch();
        logic [3:0] acks;
        i2c_start();
        write_byte(8'h90, 8'h00, acks[3]);
        write_byte(8'h02, 8'h00, acks[2]);
        write_byte(8'hAB, 8'h80, acks[1]);
        write_byte(8'hCD, 8'h00, acks[0]);
        i2c_stop();
        checks++; if (acks !== 4'hF) begin errors++; $display("[TB] FAIL glitch_acks got=%b exp=1111", acks); end
        checks++; if (lo_thresh_o !== 16'hABCD) begin errors++; $display("[TB] FAIL glitch_lo_write got=%h exp=abcd", lo_thresh_o); end
    endtask

    task automatic test_reset_mid_read();
        logic ack; logic [7:0] b0, b1;
        i2c_start();
        write_byte(8'h90, 8'h00, ack);
        write_byte(8'h03, 8'h00, ack);
        i2c_start();
        write_byte(8'h91, 8'h00, ack);
        waitq();
        checks++; if (sda_oe !== 1'b1) begin errors++; $display("[TB] FAIL midrd_driving got=%b exp=1", sda_oe); end
        sys_rst = 1'b1;
        #1;
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("[TB] FAIL midrd_rst_release got=%b exp=0", sda_oe); end
        checks++; if ({cfg_o, lo_thresh_o, hi_thresh_o} !== {16'h8583, 16'h8000, 16'h7FFF}) begin
            errors++; $display("[TB] FAIL midrd_rst_regs got=%h/%h/%h exp=8583/8000/7fff", cfg_o, lo_thresh_o, hi_thresh_o);
        end
        sda_m = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 scl_m = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        repeat (20) @(posedge sys_clk);
        #1;
        i2c_start();
        write_byte(8'h91, 8'h00, ack);
        read_byte(1'b1, b0);
        read_byte(1'b0, b1);
        i2c_stop();
        checks++; if ({ack, b0, b1} !== {1'b1, 16'h0000}) begin errors++; $display("[TB] FAIL post_rst_conv_read got=%b/%h%h exp=1/0000", ack, b0, b1); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_read_ptr0();
        test_cfg_write();
        test_conv_read();
        test_mid_read_done();
        test_addr_mismatch();
        test_partial_write();
        test_glitch();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ads111x_i2c_target.md
Name: ads111x_i2c_target

Overview:
- Synthesizable I2C target (responder) that emulates the ADS111x register map: pointer, conversion, config, Lo_thresh and Hi_thresh registers.
- It is the bus-side counterpart of the team's ADS111x master controller. It serves as a loopback/verification target on FPGA and in simulation.
- SCL and SDA are oversampled on sys_clk. Conversion data comes from a local source (stub ADC model or pattern generator) through a start/done handshake.

Parameters:
- ADDR_PIN, 2'b00, low two bits of the 7-bit address; the full address is {5'b10010, ADDR_PIN}, i.e. 0x48..0x4B.
- FILT_LEN, 3, number of consecutive identical sys_clk samples required before a filtered SCL/SDA level changes.
- HOLD_CYC, 4, sys_clk cycles after a detected SCL falling edge before sda_oe may change.

Ports:
- sys_clk  in  1  system clock; must be at least 20x the SCL frequency.
- sys_rst  in  1  asynchronous, active-high reset.
- scl_i  in  1  raw SCL from the pad.
- sda_i  in  1  raw SDA from the pad.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- conv_start  out  1  one-cycle pulse requesting a conversion.
- conv_done  in  1  one-cycle pulse; conv_data is valid in the same cycle.
- conv_data  in  16  conversion result.
- cfg_o  out  16  current config register.
- lo_thresh_o  out  16  current Lo_thresh register.
- hi_thresh_o  out  16  current Hi_thresh register.

Behaviour:
- Reset (asynchronous, active-high):
  - sda_oe=0, conv_start=0, FSM=IDLE, pointer=0, busy=0.
  - cfg=16'h8583, lo=16'h8000, hi=16'h7FFF, conv=16'h0000.
  - Reset asserted mid-transfer releases SDA in the same cycle.
- Input conditioning:
  - 2-FF synchronizer, then the FILT_LEN glitch filter.
  - Edge detection runs on the filtered signals.
  - START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
- Bit sampling: data is sampled on the filtered SCL rising edge. sda_oe updates HOLD_CYC cycles after an SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_MSB, WR_MSB_ACK, WR_LSB, WR_LSB_ACK, RD_BYTE, RD_ACK, IGNORE.
- START from any state goes to ADDR (covers repeated start); the bit counter clears. STOP from any state goes to IDLE and releases SDA.
- ADDR: shift in 8 bits, MSB first.
  - Match on {5'b10010, ADDR_PIN}: drive ACK low through the 9th SCL pulse, release after the 9th falling edge.
  - Match with R/W=0: next state PTR.
  - Match with R/W=1: next state RD_BYTE.
  - Mismatch: no ACK, go to IGNORE, which waits for START or STOP.
- PTR byte:
  - pointer <= bits[1:0]; upper bits are ignored. ACK the byte.
  - Go to WR_MSB. A STOP or START arriving here leaves only the pointer updated.
- WR_MSB, WR_LSB:
  - ACK each byte.
  - The register is committed in the cycle after the LSB's 8th rising edge.
  - A START or STOP before commit discards the partial word; the register is unchanged.
  - Further byte pairs in the same transfer write the same pointer again.
- Write targets:
  - Pointer 0 (conversion) is read-only; its bytes are ACKed and discarded.
  - Pointer 1 stores cfg. If written bit15=1 and busy=0: pulse conv_start for 1 cycle and set busy=1. Bit15 is not stored; stored OS is always 1.
  - Pointer 2 writes lo; pointer 3 writes hi.
- Read path:
  - The 16-bit value for the current pointer is snapshotted at the start of each MSB byte.
  - Pointer 1 reads {~busy, cfg[14:0]}.
  - Bytes are driven MSB first, alternating MSB, LSB, MSB, ... for as long as the master ACKs.
  - In RD_ACK, SDA is released and the master's bit is sampled on the 9th rising edge. ACK continues with the next byte; NACK goes to IGNORE.
  - A read with no preceding write uses the last pointer.
- Conversion handshake:
  - conv_done: conv <= conv_data, busy <= 0.
  - conv_done arriving in the same cycle as a conv_start request: the done is taken first, then the new start is accepted, so busy ends at 1.
  - conv_done arriving mid-read does not alter the bytes already snapshotted.
- Bus rule: the target never drives SDA high; sda_oe=1 is only asserted while SCL is low or while holding an ACK/data bit.

Test Plan:
- Reset, then read with address 0x91 (ADDR_PIN=00), ptr=0 -> ACKs; bytes 0x00, 0x00; master NACK on byte 2 -> IGNORE; STOP -> IDLE, sda_oe=0.
- Write 0x90, 0x01, 0xC4, 0xE3 -> cfg_o=16'h44E3 (OS not stored, stored OS=1), conv_start pulses exactly once. Read ptr1 before conv_done -> 0x44E3. After conv_done -> 0xC4E3.
- conv_done with conv_data=16'h1234, then write ptr 0x00 and repeated-start read 0x91 for 4 bytes -> 0x12, 0x34, 0x12, 0x34.
- Address 0x92 sent while ADDR_PIN=00 -> no ACK, sda_oe stays 0 for the whole transfer; a subsequent START with 0x90 is ACKed normally.
- Write 0x90, 0x02, 0xAB, then STOP -> lo_thresh_o remains 16'h8000 and pointer=2. Write 0x90, 0x03, 0x12, 0x34 -> hi_thresh_o=16'h1234.
- Assert sys_rst while driving a read data bit low -> sda_oe=0 immediately; all registers return to their reset values. A 1-cycle SDA glitch with SCL high produces no START/STOP detection (FILT_LEN=3).
